// File: rtl/proc_pkg.sv
// Shared types for the parametrised accumulator CPU: FSM state encoding and opcode values.
package proc_pkg;

  typedef enum logic [3:0] {
    RESET_PC,
    FETCH,
    DECODE,
    EX_ADD,
    EX_SUB,
    EX_LOAD,
    EX_STORE,
    EX_LOADI,
    EX_JUMP,
    EX_JNEG,
    EX_JZERO,
    HALT
  } state_e;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_LOAD  = 2;
  localparam int unsigned OP_STORE = 3;
  localparam int unsigned OP_JUMP  = 4;
  localparam int unsigned OP_JNEG  = 5;
  localparam int unsigned OP_JZERO = 6;
  localparam int unsigned OP_LOADI = 7;
  localparam int unsigned OP_HALT  = 15;

endpackage

// File: rtl/proc_alu.sv
// Combinational adder/subtractor with two's-complement overflow detection.
module proc_alu #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  always_comb begin
    result = sub ? (a - b) : (a + b);
    // Overflow: operands effectively share a sign but the result sign flips.
    if (sub) begin
      ovf = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
    end else begin
      ovf = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
    end
  end

endmodule

// File: rtl/processador_param.sv
// Multicycle accumulator CPU with one shared instruction/data memory port and a
// wait-state handshake (mem_ready).
module processador_param
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] ir,
  output logic              ovf,
  output logic              halted
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] ir_q;
  logic              ovf_q;
  logic              req_q;
  logic              halted_q;

  logic [OPC_W-1:0]  op;
  logic [ADDR_W-1:0] a_fld;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;

  assign op    = ir_q[ADDR_W+OPC_W-1:ADDR_W];
  assign a_fld = ir_q[ADDR_W-1:0];

  proc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (acc_q),
    .b      (mem_rdata),
    .sub    (state_q == EX_SUB),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  always_comb begin
    mem_addr = (state_q == FETCH) ? pc_q : a_fld;
    mem_we   = (state_q == EX_STORE);
  end

  // mem_req is registered alongside the state so it is high exactly while in an access state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RESET_PC;
      pc_q     <= '0;
      acc_q    <= '0;
      ir_q     <= '0;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        RESET_PC: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= DECODE;
            req_q   <= 1'b0;
          end
        end
        DECODE: begin
          case (op)
            OPC_W'(OP_ADD):   begin state_q <= EX_ADD;   req_q <= 1'b1; end
            OPC_W'(OP_SUB):   begin state_q <= EX_SUB;   req_q <= 1'b1; end
            OPC_W'(OP_LOAD):  begin state_q <= EX_LOAD;  req_q <= 1'b1; end
            OPC_W'(OP_STORE): begin state_q <= EX_STORE; req_q <= 1'b1; end
            OPC_W'(OP_JUMP):  state_q <= EX_JUMP;
            OPC_W'(OP_JNEG):  state_q <= EX_JNEG;
            OPC_W'(OP_JZERO): state_q <= EX_JZERO;
            OPC_W'(OP_LOADI): state_q <= EX_LOADI;
            OPC_W'(OP_HALT): begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
            default: begin state_q <= FETCH; req_q <= 1'b1; end
          endcase
        end
        EX_ADD, EX_SUB: begin
          if (mem_ready) begin
            acc_q   <= alu_result;
            ovf_q   <= alu_ovf;
            state_q <= FETCH;
          end
        end
        EX_LOAD: begin
          if (mem_ready) begin
            acc_q   <= mem_rdata;
            state_q <= FETCH;
          end
        end
        EX_STORE: begin
          if (mem_ready) state_q <= FETCH;
        end
        EX_LOADI: begin
          acc_q   <= DATA_W'(a_fld);
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        EX_JUMP, EX_JNEG, EX_JZERO: begin
          if ((state_q == EX_JUMP) ||
              ((state_q == EX_JNEG) && acc_q[DATA_W-1]) ||
              ((state_q == EX_JZERO) && (acc_q == '0))) begin
            pc_q <= a_fld;
          end
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        HALT: state_q <= HALT;
        default: state_q <= RESET_PC;
      endcase
    end
  end

  assign mem_wdata = acc_q;
  assign mem_req   = req_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign ir        = ir_q;
  assign ovf       = ovf_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_processador_param.sv
// Directed and randomized checks of processador_param against an instruction-level model.
module tb_processador_param;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_req;
  logic              mem_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir;
  logic              ovf;
  logic              halted;

  logic [15:0] ram [256];
  logic [15:0] mdl [256];
  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt;
  logic [7:0] we_addr;

  processador_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .OPC_W (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_req  (mem_req),
    .mem_ready(mem_ready),
    .pc       (pc),
    .acc      (acc),
    .ir       (ir),
    .ovf      (ovf),
    .halted   (halted)
  );

  assign mem_rdata = ram[mem_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ins(input int op, input int a);
    return 16'((op << 8) | (a & 255));
  endfunction

  // Wait for the next falling edge, present mem_ready for the following rising edge and
  // commit a store the RAM will accept on that edge.
  task automatic step(input bit rdy);
    @(negedge clock);
    mem_ready = rdy;
    if (mem_we && rdy) begin
      ram[mem_addr] = mem_wdata;
      we_cnt++;
      we_addr = mem_addr;
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
  endtask

  task automatic start(input bit rdy);
    reset     = 1'b0;
    mem_ready = rdy;
    we_cnt    = 0;
    we_addr   = 8'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input bit rnd, input int budget);
    for (int i = 0; i < budget && !halted; i++) step(rnd ? (($urandom % 3) != 0) : 1'b1);
    if (!halted) check("halt_timeout", {31'b0, halted}, 32'd1);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom % 6)
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      4: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] m_acc, m_ir, b;
    logic [7:0]  m_pc, a;
    logic        m_ovf;
    int          s, sa, sb, op, n_st;

    reset = 1'b0;
    mem_ready = 1'b1;
    we_cnt = 0;
    we_addr = 8'h0;

    // 1: LOADI then HALT, plus reset state
    clear_ram();
    ram[0] = ins(7, 5);
    ram[1] = ins(15, 0);
    start(1'b1);
    reset = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_flags", {28'b0, ovf, mem_we, mem_req, halted}, 32'h0);
    start(1'b1);
    step(1'b1);
    check("t1_fetch", {23'b0, mem_req, mem_addr}, 32'h100);
    step(1'b1); step(1'b1);
    check("t1_acc_c3", 32'(acc), 32'h0);
    step(1'b1);
    check("t1_acc_c4", 32'(acc), 32'h5);
    step(1'b1);
    check("t1_not_halted", {31'b0, halted}, 32'h0);
    step(1'b1); step(1'b1); step(1'b1);
    check("t1_halted", {31'b0, halted}, 32'h1);
    check("t1_pc", 32'(pc), 32'h2);
    check("t1_req", {31'b0, mem_req}, 32'h0);

    // 2: LOAD/ADD/STORE with overflow into 0x8000
    clear_ram();
    ram[0] = ins(2, 8'h10);
    ram[1] = ins(0, 8'h11);
    ram[2] = ins(3, 8'h12);
    ram[3] = ins(15, 0);
    ram[8'h10] = 16'h7FFF;
    ram[8'h11] = 16'h0001;
    start(1'b1);
    run_to_halt(1'b0, 40);
    check("t2_mem", 32'(ram[8'h12]), 32'h8000);
    check("t2_ovf", {31'b0, ovf}, 32'h1);
    check("t2_we_cnt", 32'(we_cnt), 32'h1);
    check("t2_we_addr", 32'(we_addr), 32'h12);

    // 3: JNEG taken / not taken, JZERO taken
    clear_ram();
    ram[0] = ins(2, 8'h40);
    ram[1] = ins(5, 8'h20);
    ram[8'h20] = ins(7, 1);
    ram[8'h21] = ins(5, 8'h30);
    ram[8'h22] = ins(7, 0);
    ram[8'h23] = ins(6, 8'h30);
    ram[8'h30] = ins(15, 0);
    ram[8'h40] = 16'hFFFF;
    start(1'b1);
    repeat (7) step(1'b1);
    check("t3_jneg_taken", 32'(pc), 32'h20);
    repeat (6) step(1'b1);
    check("t3_jneg_not", 32'(pc), 32'h22);
    repeat (6) step(1'b1);
    check("t3_jzero", 32'(pc), 32'h30);
    check("t3_fetch_addr", 32'(mem_addr), 32'h30);

    // most-negative accumulator: JNEG taken, SUB 1 wraps with overflow
    clear_ram();
    ram[0] = ins(2, 8'h40);
    ram[1] = ins(5, 8'h05);
    ram[5] = ins(1, 8'h41);
    ram[6] = ins(15, 0);
    ram[8'h40] = 16'h8000;
    ram[8'h41] = 16'h0001;
    start(1'b1);
    repeat (7) step(1'b1);
    check("mn_jneg", 32'(pc), 32'h5);
    run_to_halt(1'b0, 40);
    check("mn_acc", 32'(acc), 32'h7FFF);
    check("mn_ovf", {31'b0, ovf}, 32'h1);

    // 4: wait states during FETCH and LOAD
    clear_ram();
    ram[0] = ins(2, 8'h40);
    ram[1] = ins(15, 0);
    ram[8'h40] = 16'h1234;
    start(1'b0);
    step(1'b0); step(1'b0); step(1'b0);
    check("t4_ir_stall", 32'(ir), 32'h0);
    check("t4_pc_stall", 32'(pc), 32'h0);
    step(1'b1);
    step(1'b0);
    check("t4_ir", 32'(ir), 32'h240);
    check("t4_pc", 32'(pc), 32'h1);
    step(1'b0); step(1'b0); step(1'b0);
    check("t4_acc_stall", 32'(acc), 32'h0);
    check("t4_load_req", {23'b0, mem_req, mem_addr}, 32'h140);
    step(1'b1);
    step(1'b1);
    check("t4_acc", 32'(acc), 32'h1234);
    check("t4_pc_once", 32'(pc), 32'h1);

    // 5: reset asserted mid-store while stalled
    clear_ram();
    ram[0] = ins(7, 7);
    ram[1] = ins(3, 8'h50);
    start(1'b1);
    repeat (5) step(1'b1);
    step(1'b0);
    check("t5_we_high", {31'b0, mem_we}, 32'h1);
    step(1'b0);
    reset = 1'b0;
    #1;
    check("t5_we_low", {30'b0, mem_we, mem_req}, 32'h0);
    check("t5_regs", {pc, acc, ir}, 40'h0);
    check("t5_no_write", 32'(ram[8'h50]), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b1);
    check("t5_refetch", {23'b0, mem_req, mem_addr}, 32'h100);

    // 6: NOP at 0xFF wraps pc
    clear_ram();
    ram[0] = ins(7, 8'h3C);
    ram[1] = ins(4, 8'hFF);
    ram[8'hFF] = ins(9, 8'hAB);
    start(1'b1);
    repeat (7) step(1'b1);
    check("t6_at_ff", 32'(mem_addr), 32'hFF);
    step(1'b1); step(1'b1);
    check("t6_wrap", {23'b0, mem_req, pc}, 32'h100);
    check("t6_addr", 32'(mem_addr), 32'h0);
    check("t6_acc", 32'(acc), 32'h3C);

    // random forward-branching programs with random wait states
    for (int t = 0; t < 20; t++) begin
      clear_ram();
      for (int i = 0; i < 30; i++) begin
        op = $urandom % 10;
        if (op == 8) ram[i] = ins(8 + ($urandom % 7), $urandom % 256);
        else if (op == 9 || op == 7) ram[i] = ins(7, $urandom % 256);
        else if (op >= 4) ram[i] = ins(op, i + 1 + ($urandom % (30 - i)));
        else ram[i] = ins(op, 8'h40 + ($urandom % 8));
      end
      ram[30] = ins(15, 0);
      for (int i = 8'h40; i < 8'h48; i++) ram[i] = pick_val();
      for (int i = 0; i < 256; i++) mdl[i] = ram[i];

      m_pc = 0; m_acc = 0; m_ovf = 0; m_ir = 0; n_st = 0;
      for (int k = 0; k < 100; k++) begin
        m_ir = mdl[m_pc];
        m_pc = m_pc + 8'd1;
        a  = m_ir[7:0];
        b  = mdl[a];
        sa = $signed(m_acc);
        sb = $signed(b);
        case (m_ir[11:8])
          4'd0, 4'd1: begin
            s = (m_ir[11:8] == 4'd0) ? sa + sb : sa - sb;
            m_ovf = (s > 32767) || (s < -32768);
            m_acc = s[15:0];
          end
          4'd2:  m_acc = b;
          4'd3:  begin mdl[a] = m_acc; n_st++; end
          4'd4:  m_pc = a;
          4'd5:  if (sa < 0) m_pc = a;
          4'd6:  if (m_acc == 16'h0) m_pc = a;
          4'd7:  m_acc = {8'h0, a};
          4'd15: break;
          default: ;
        endcase
      end

      start(1'b1);
      run_to_halt(1'b1, 1500);
      check("rnd_acc", 32'(acc), 32'(m_acc));
      check("rnd_pc", 32'(pc), 32'(m_pc));
      check("rnd_ovf", {31'b0, ovf}, {31'b0, m_ovf});
      check("rnd_ir", 32'(ir), 32'(m_ir));
      check("rnd_stores", 32'(we_cnt), 32'(n_st));
      for (int i = 8'h40; i < 8'h48; i++) check("rnd_mem", 32'(ram[i]), 32'(mdl[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
